pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, SHALL set the memory wait-state count per MEM-stage access; legal range 1..15.
REQ-002 Parameter CNT_W, default 16, SHALL set the performance-counter width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port hazard  input  1  SHALL carry the RAW-hazard flag for the instruction in ID.
REQ-006 Port branch_taken  input  1  SHALL carry the taken-branch flag from EX.
REQ-007 Port mem_req  input  1  SHALL flag a load/store in MEM (read or write enable).
REQ-008 Port clr_stats  input  1  SHALL be a synchronous clear of both counters.
REQ-009 Port freeze_pc  output  1  SHALL hold the PC and the IF/ID register.
REQ-010 Port freeze_back  output  1  SHALL hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-011 Port flush_if  output  1  SHALL zero the IF/ID register on the next edge.
REQ-012 Port bubble_id  output  1  SHALL load a NOP into ID/EX on the next edge.
REQ-013 Port mem_done  output  1  SHALL pulse high for the single cycle in which a memory access completes.
REQ-014 Ports stall_cnt, flush_cnt  output  CNT_W  SHALL report stalled cycles and branch flushes.

Function
REQ-015 Memory FSM states SHALL be IDLE, WAIT, DONE.
REQ-016 IDLE with mem_req=1 SHALL go to WAIT and load the wait counter with WAIT_CYCLES-1; otherwise remain in IDLE.
REQ-017 WAIT SHALL decrement the counter each cycle and go to DONE when the counter equals 0.
REQ-018 DONE SHALL return to IDLE unconditionally and ignore mem_req, since the same instruction is still in MEM.
REQ-019 mem_busy SHALL be (IDLE and mem_req) or WAIT; a memory access therefore occupies WAIT_CYCLES+2 cycles, with mem_busy high for WAIT_CYCLES+1 of them.
REQ-020 mem_done SHALL be high exactly when the state is DONE.
REQ-021 Priority 1: mem_busy=1 SHALL assert freeze_pc and freeze_back, and SHALL force flush_if=0 and bubble_id=0, regardless of hazard and branch_taken.
REQ-022 Priority 2: mem_busy=0 with branch_taken=1 SHALL assert flush_if and bubble_id, with freeze_pc=0 so the branch target is fetched; hazard is ignored.
REQ-023 Priority 3: mem_busy=0, branch_taken=0 and hazard=1 SHALL assert freeze_pc and bubble_id, with flush_if=0 and freeze_back=0.
REQ-024 With none of the above conditions true, all four control outputs SHALL be 0.
REQ-025 Control outputs SHALL be combinational from the FSM state and inputs, with zero-cycle latency.
REQ-026 stall_cnt SHALL increment on every cycle freeze_pc=1; flush_cnt SHALL increment on every cycle flush_if=1.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr_stats=1 SHALL zero both counters on the next edge and SHALL take priority over a same-cycle increment.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, wait counter 0, stall_cnt 0, flush_cnt 0.
REQ-030 While rst_n=0, freeze_pc, freeze_back, flush_if, bubble_id and mem_done SHALL all be 0, irrespective of the inputs.
REQ-031 Reset asserted mid-access (WAIT) SHALL abandon the access; after release the FSM SHALL start a fresh access if mem_req=1.

Structure
REQ-032 A shared package pipe_ctrl_pkg SHALL hold the FSM state enum and the WAIT_CYCLES and CNT_W defaults.
REQ-033 The memory FSM and wait counter SHALL be a sub-module mem_wait_fsm (outputs mem_busy, mem_done); priority logic and counters SHALL stay in pipe_ctrl.

Verification
REQ-034 WAIT_CYCLES=3, one-cycle mem_req pulse held until done -> freeze_pc/freeze_back high 4 cycles, mem_done high on cycle 5, stall_cnt=4.
REQ-035 branch_taken=1 and hazard=1 in the same cycle, no mem -> flush_if=1, bubble_id=1, freeze_pc=0, flush_cnt increments by 1.
REQ-036 hazard=1 for 2 cycles, no mem/branch -> freeze_pc=1 and bubble_id=1 for 2 cycles, freeze_back=0, stall_cnt=2.
REQ-037 branch_taken=1 during WAIT -> no flush until DONE; flush_if asserted in the DONE cycle if branch_taken is still high.
REQ-038 Preload stall_cnt near saturation (CNT_W=4) and hold hazard for 20 cycles -> stall_cnt sticks at 15; clr_stats=1 together with hazard=1 -> stall_cnt=0.
REQ-039 rst_n pulled low in WAIT -> all outputs 0 immediately; after release with mem_req=1 -> full WAIT_CYCLES+2-cycle access observed.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int unsigned WAIT_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned WCNT_W          = 4;

endpackage

// File: rtl/mem_wait_fsm.sv
// MEM-stage wait-state sequencer: IDLE -> WAIT (WAIT_CYCLES cycles) -> DONE.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    output logic mem_busy,
    output logic mem_done
);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // DONE ignores mem_req: the finishing instruction is still sitting in MEM.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        mem_busy = 1'b0;
        mem_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    mem_busy = rst_n;
                    state_d  = ST_WAIT;
                    wcnt_d   = WCNT_W'(WAIT_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                mem_busy = rst_n;
                if (wcnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ST_DONE: begin
                mem_done = rst_n;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory stall > branch flush > RAW bubble, plus
// saturating stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             clr_stats,
    output logic             freeze_pc,
    output logic             freeze_back,
    output logic             flush_if,
    output logic             bubble_id,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             mem_busy;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    mem_wait_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_mem_wait_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (mem_req),
        .mem_busy (mem_busy),
        .mem_done (mem_done)
    );

    // Zero-latency control; everything held low while reset is asserted.
    always_comb begin
        freeze_pc   = 1'b0;
        freeze_back = 1'b0;
        flush_if    = 1'b0;
        bubble_id   = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                freeze_pc   = 1'b1;
                freeze_back = 1'b1;
            end else if (branch_taken) begin
                flush_if  = 1'b1;
                bubble_id = 1'b1;
            end else if (hazard) begin
                freeze_pc = 1'b1;
                bubble_id = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (clr_stats) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (freeze_pc && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
            if (flush_if && (flush_q != CNT_MAX))  flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
